pool_flatten: RTL and testbench
===============================

# pool_flatten

Flattening stage directly downstream of the pooling block. Absorbs pooled pixel vectors (all channels of one pixel per beat) into a small vector FIFO. Streams them out one element per cycle in HWC order over a valid/ready handshake to the fully-connected layer. Provides frame framing (`out_last`, `out_index`, `done`) and an `almost_full` flag so the controller can deassert pooling `en` before data is lost.

## Interface
- `pDATA_WIDTH`, 8, bits per element
- `pCHANNEL`, 32, elements per input vector
- `pOUT_WIDTH`, 14, pooled map width (pixels per row)
- `pOUT_HEIGHT`, 14, pooled map height
- `pFIFO_DEPTH`, 4, vector slots; power of two, >= 2
- `pAFULL_MARGIN`, 1, free-slot threshold for `almost_full`; must be < `pFIFO_DEPTH`
- Derived: `TOTAL = pOUT_WIDTH*pOUT_HEIGHT*pCHANNEL`; `IW = $clog2(TOTAL)`
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous assert, active-low (0 = reset)
- `en`  in  1  block enable
- `in_valid`  in  1  `data_in` holds a pooled vector this cycle (pooling `valid`)
- `data_in`  in  `pDATA_WIDTH*pCHANNEL`  vector; channel c at bits `[c*pDATA_WIDTH +: pDATA_WIDTH]`
- `out_data`  out  `pDATA_WIDTH`  current element
- `out_valid`  out  1  `out_data` valid
- `out_ready`  in  1  consumer accepts element
- `out_last`  out  1  current element is index `TOTAL-1`
- `out_index`  out  IW  flat index of current element = pixel*pCHANNEL + channel
- `almost_full`  out  1  FIFO count >= `pFIFO_DEPTH - pAFULL_MARGIN`
- `overflow`  out  1  sticky: a vector was dropped
- `done`  out  1  one-cycle pulse after frame's last element is accepted

## Operation
- **FIFO write:** Accepted when `en && in_valid` and one of the following holds:
  - count < `pFIFO_DEPTH`, or
  - the head vector retires this same cycle.
- **Dropped writes:** A write with `en && in_valid` while full and not retiring is dropped and sets `overflow`. `overflow` clears only on reset.
- **`en` low:**
  - `in_valid` is ignored; no write and no overflow.
  - `out_valid` is forced 0.
  - Counters and FIFO hold.
- **Handshake:** A transfer occurs when `out_valid && out_ready`. Each transfer increments the channel counter `ch` (0..`pCHANNEL-1`) and `out_index`.
- **Head retire:** When `ch` wraps from `pCHANNEL-1`, the head vector retires (read pointer advances, count decrements).
- **Output mux:** `out_data` is the head vector sliced at `ch`, channel 0 first.
- **States:**
  - IDLE: count==0, `out_valid`=0. Goes to STREAM on the first accepted write.
  - STREAM: `out_valid` = (count!=0) && `en`. On transfer with `out_last`, goes to DONE.
  - DONE: one cycle. `done`=1, `out_valid`=0. `ch` and `out_index` are reset to 0. Writes are still accepted. Next state is STREAM if count!=0, else IDLE.
- **Underflow:** When count reaches 0 mid-frame, the block remains in STREAM with `out_valid`=0. `out_index` and `ch` hold.
- **Widths:**
  - count is `$clog2(pFIFO_DEPTH)+1` bits.
  - Pointers are `$clog2(pFIFO_DEPTH)` bits and wrap naturally.
  - `out_index` never exceeds `TOTAL-1`.

## Timing
- **Reset values:** On reset (`rst`=0), all outputs are 0. FIFO count, pointers, `ch`, `out_index` are 0. State is IDLE. Reset mid-frame discards all buffered data.
- **Latency:** A vector written at edge N produces `out_valid`=1 from cycle N+1. `out_data`, `out_last`, and `out_index` are combinational from registered state.
- **Throughput:**
  - One element per cycle while `out_ready`=1.
  - One vector drains in `pCHANNEL` cycles.
  - DONE inserts one bubble per frame.
- **Holding:** `out_data` and `out_index` hold stable while `out_valid && !out_ready`.
- **`almost_full`:** Registered-state derived; updates the cycle after the count change.
- **Simultaneous write + retire at full:** The write is accepted and count stays at `pFIFO_DEPTH`. No overflow.
- **Simultaneous write + retire otherwise:** count unchanged.

## Test plan
Parameters for scenarios 1-5: `pCHANNEL`=4, `pOUT_WIDTH`=`pOUT_HEIGHT`=2, `pFIFO_DEPTH`=4, `pAFULL_MARGIN`=1, `pDATA_WIDTH`=8.

1. **Single vector ordering.** Reset, then `en`=1, `out_ready`=1, write `data_in`=32'h04030201.
   - Next 4 cycles: `out_data` = 01, 02, 03, 04, with `out_index` = 0..3.
   - Then `out_valid`=0.
2. **Full frame.** Write 4 vectors back-to-back, `out_ready`=1.
   - 16 consecutive transfers.
   - `out_last`=1 only at `out_index`=15.
   - `done`=1 exactly one cycle later; state returns to IDLE.
3. **Backpressure and almost_full.** Hold `out_ready`=0 and write 3 vectors.
   - `almost_full` rises after the 3rd write.
   - `out_data`=01 and `out_index`=0 are stable throughout.
4. **Overflow and full-boundary write.**
   - 5th write while full with `out_ready`=0: dropped; `overflow` goes to 1 and stays.
   - Repeat the full case with the 4th element of the head being accepted in the same cycle as the write: write accepted, `overflow` stays 0.
5. **`en` gating and reset.** Mid-frame (`out_index`=6), drive `en`=0 for 3 cycles.
   - `out_valid`=0 and `out_index` holds at 6.
   - Then assert `rst`=0 asynchronously between edges: all outputs go to 0 immediately.
   - Next frame starts at `out_index`=0.

Source files
------------

// File: rtl/pool_flatten.sv
// pool_flatten: buffers pooled pixel vectors in a small FIFO and streams them
// out one element per cycle, channel 0 first, with frame framing signals.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no frame in progress, FIFO empty, out_valid low
// STREAM | frame in progress; elements presented whenever FIFO is non-empty
// DONE   | one-cycle bubble after the frame's last element; done pulses
module pool_flatten #(
    parameter int pDATA_WIDTH   = 8,
    parameter int pCHANNEL      = 32,
    parameter int pOUT_WIDTH    = 14,
    parameter int pOUT_HEIGHT   = 14,
    parameter int pFIFO_DEPTH   = 4,
    parameter int pAFULL_MARGIN = 1,
    localparam int TOTAL = pOUT_WIDTH * pOUT_HEIGHT * pCHANNEL,
    localparam int IW    = $clog2(TOTAL)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic                            in_valid,
    input  logic [pDATA_WIDTH*pCHANNEL-1:0] data_in,
    output logic [pDATA_WIDTH-1:0]          out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            out_last,
    output logic [IW-1:0]                   out_index,
    output logic                            almost_full,
    output logic                            overflow,
    output logic                            done
);

    localparam int VW   = pDATA_WIDTH * pCHANNEL;
    localparam int PW   = $clog2(pFIFO_DEPTH);
    localparam int CNTW = PW + 1;
    localparam int CW   = (pCHANNEL > 1) ? $clog2(pCHANNEL) : 1;

    localparam logic [IW-1:0]   LAST_IDX = IW'(TOTAL - 1);
    localparam logic [CW-1:0]   LAST_CH  = CW'(pCHANNEL - 1);
    localparam logic [CNTW-1:0] DEPTH_C  = CNTW'(pFIFO_DEPTH);
    localparam logic [CNTW-1:0] AFULL_C  = CNTW'(pFIFO_DEPTH - pAFULL_MARGIN);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t          state;
    logic [VW-1:0]   mem [pFIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CNTW-1:0] count;
    logic [CNTW-1:0] count_nxt;
    logic [CW-1:0]   ch;
    logic [IW-1:0]   idx;
    logic            ovf_q;

    logic            head_valid;
    logic            xfer;
    logic            at_last;
    logic            retire;
    logic            wr_ok;
    logic            drop;

    // Handshake, retire and write-acceptance decode from registered state
    always_comb begin
        head_valid = (state == S_STREAM) && (count != '0) && en;
        xfer       = head_valid && out_ready;
        at_last    = (idx == LAST_IDX);
        retire     = xfer && (ch == LAST_CH);
        // A retiring head frees its slot in the same cycle, so a full FIFO
        // can still take a new vector then.
        wr_ok      = en && in_valid && ((count < DEPTH_C) || retire);
        drop       = en && in_valid && !wr_ok;
        count_nxt  = count;
        if (wr_ok && !retire) begin
            count_nxt = count + CNTW'(1);
        end else if (retire && !wr_ok) begin
            count_nxt = count - CNTW'(1);
        end
    end

    assign out_valid   = head_valid;
    assign out_data    = head_valid ? mem[rd_ptr][ch*pDATA_WIDTH +: pDATA_WIDTH] : '0;
    assign out_last    = head_valid && at_last;
    assign out_index   = idx;
    assign almost_full = (count >= AFULL_C);
    assign overflow    = ovf_q;
    assign done        = (state == S_DONE);

    // Vector storage; contents are meaningless until the pointers cover them
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (retire) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_nxt;
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Frame sequencing: channel counter, flat index and state transitions
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            ch    <= '0;
            idx   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (wr_ok) begin
                        state <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (xfer) begin
                        ch <= (ch == LAST_CH) ? '0 : ch + CW'(1);
                        if (at_last) begin
                            idx   <= '0;
                            state <= S_DONE;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                S_DONE: begin
                    ch    <= '0;
                    idx   <= '0;
                    // A write landing during the bubble must restart streaming
                    state <= (count_nxt != '0) ? S_STREAM : S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pool_flatten.sv
// Self-checking bench for pool_flatten: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// queue-based reference model of the flattening behaviour.
module tb_pool_flatten;

    localparam int DW     = 8;
    localparam int C      = 4;
    localparam int OW     = 2;
    localparam int OH     = 2;
    localparam int DEPTH  = 4;
    localparam int MARGIN = 1;
    localparam int TOTAL  = OW * OH * C;
    localparam int IW     = $clog2(TOTAL);
    localparam int VW     = DW * C;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          in_valid;
    logic [VW-1:0] data_in;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic [IW-1:0] out_index;
    logic          almost_full;
    logic          overflow;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    pool_flatten #(
        .pDATA_WIDTH  (DW),
        .pCHANNEL     (C),
        .pOUT_WIDTH   (OW),
        .pOUT_HEIGHT  (OH),
        .pFIFO_DEPTH  (DEPTH),
        .pAFULL_MARGIN(MARGIN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .in_valid   (in_valid),
        .data_in    (data_in),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .out_index  (out_index),
        .almost_full(almost_full),
        .overflow   (overflow),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: queue of buffered vectors, flat element position in
    // the frame, pending done pulse and sticky overflow.
    logic [VW-1:0] q[$];
    int            elem     = 0;
    bit            done_now = 0;
    bit            ovf      = 0;

    // Inputs are stable from posedge+1 until the next posedge, so the model
    // checks the current cycle and then steps across the coming edge.
    always @(negedge clk) begin
        bit            exp_ov;
        bit            xfer;
        bit            retire;
        bit            wr;
        logic [VW-1:0] vec;
        if (!rst) begin
            q.delete();
            elem     = 0;
            done_now = 0;
            ovf      = 0;
            check("rst_out_valid", out_valid, 0);
            check("rst_done", done, 0);
            check("rst_almost_full", almost_full, 0);
            check("rst_overflow", overflow, 0);
            check("rst_out_index", out_index, 0);
        end else begin
            exp_ov = en && (q.size() != 0) && !done_now;
            check("out_valid", out_valid, exp_ov);
            check("done", done, done_now);
            check("almost_full", almost_full, q.size() >= DEPTH - MARGIN);
            check("overflow", overflow, ovf);
            if (exp_ov) begin
                vec = q[0];
                check("out_data", out_data, vec[(elem % C)*DW +: DW]);
                check("out_index", out_index, elem);
                check("out_last", out_last, elem == TOTAL - 1);
            end
            xfer   = exp_ov && out_ready;
            retire = xfer && (elem % C == C - 1);
            wr     = en && in_valid && ((q.size() < DEPTH) || retire);
            if (en && in_valid && !wr) ovf = 1;
            done_now = xfer && (elem == TOTAL - 1);
            if (retire) void'(q.pop_front());
            if (wr) q.push_back(data_in);
            if (xfer) elem = (elem == TOTAL - 1) ? 0 : elem + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        tick();
        rst = 1'b1;
    endtask

    task automatic write_vec(input logic [VW-1:0] v);
        data_in  = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        bit hit;
        rst       = 1'b0;
        en        = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
        #3;
        check("init_out_data", out_data, 0);
        check("init_out_last", out_last, 0);
        check("init_done", done, 0);
        repeat (2) tick();
        rst = 1'b1;

        // Single vector ordering, then complete the frame with 3 more vectors
        en        = 1'b1;
        out_ready = 1'b1;
        write_vec(32'h04030201);
        for (int k = 0; k < C; k++) begin
            @(negedge clk);
            check("s1_data", out_data, k + 1);
            check("s1_index", out_index, k);
        end
        @(negedge clk);
        check("s1_drained", out_valid, 0);
        tick();
        write_vec(32'h08070605);
        write_vec(32'h0c0b0a09);
        write_vec(32'h100f0e0d);
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            if (out_valid && out_last) hit = 1;
        end
        check("s2_last_seen", hit, 1);
        check("s2_last_index", out_index, 15);
        check("s2_last_data", out_data, 8'h10);
        @(negedge clk);
        check("s2_done", done, 1);
        check("s2_done_valid", out_valid, 0);
        @(negedge clk);
        check("s2_done_pulse", done, 0);
        tick();

        // Backpressure and almost_full
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_in  = (i == 0) ? 32'h04030201 : $urandom;
            in_valid = 1'b1;
            if (i == 2) begin
                @(negedge clk);
                check("s3_af_before", almost_full, 0);
            end
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("s3_af_after", almost_full, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("s3_hold_data", out_data, 8'h01);
            check("s3_hold_index", out_index, 0);
        end
        tick();

        // Overflow when full and not retiring
        write_vec($urandom);
        @(negedge clk);
        check("s4_ovf_before", overflow, 0);
        tick();
        write_vec($urandom);
        @(negedge clk);
        check("s4_ovf_set", overflow, 1);
        repeat (3) tick();
        check("s4_ovf_sticky", overflow, 1);

        // Full-boundary write coinciding with head retire
        do_reset();
        for (int i = 0; i < DEPTH; i++) write_vec($urandom);
        out_ready = 1'b1;
        repeat (3) tick();
        data_in  = $urandom;
        in_valid = 1'b1;
        @(negedge clk);
        check("s4b_index", out_index, 3);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("s4b_no_ovf", overflow, 0);
        check("s4b_still_full", almost_full, 1);
        check("s4b_next_index", out_index, 4);

        // en gating mid-frame, then asynchronous reset
        do_reset();
        out_ready = 1'b1;
        write_vec(32'h44332211);
        write_vec(32'h88776655);
        hit = 0;
        for (int i = 0; i < 30 && !hit; i++) begin
            if (out_valid && out_index == 6) hit = 1;
            else tick();
        end
        check("s5_reach_6", hit, 1);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("s5_gated_valid", out_valid, 0);
            check("s5_gated_index", out_index, 6);
        end
        tick();
        en = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("s5_arst_valid", out_valid, 0);
        check("s5_arst_index", out_index, 0);
        check("s5_arst_data", out_data, 0);
        check("s5_arst_last", out_last, 0);
        check("s5_arst_af", almost_full, 0);
        check("s5_arst_ovf", overflow, 0);
        check("s5_arst_done", done, 0);
        @(negedge clk);
        tick();
        rst = 1'b1;
        write_vec(32'hddccbbaa);
        @(negedge clk);
        check("s5_restart_valid", out_valid, 1);
        check("s5_restart_index", out_index, 0);
        check("s5_restart_data", out_data, 8'haa);
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            en        = ($urandom_range(0, 9) != 0);
            in_valid  = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 9) < 7);
            data_in   = $urandom;
            tick();
        end
        en        = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (40) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
